// File: rtl/nios2_debug_action_sched.sv
// nios2_debug_action_sched
//
// Sequencer between the debug-slave sysclk-side action strobes and the shared
// OCI register/memory command port. Each take_action_* strobe is captured with
// its jdo payload into a small FIFO. Queued commands are issued one at a time
// over a valid/ready request. The sequencer then waits for a done/error
// response, with a timeout.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   jdo                   JTAG payload, sampled together with any strobe
//   take_action_*         1-cycle action strobes (type codes 0..5)
//   cmd_valid/cmd_ready   command handshake to the OCI port
//   cmd_type/cmd_payload  head-of-queue command, held while cmd_valid is high
//   cmd_done/cmd_err      completion pulse and its failure qualifier
//   clr_status            clears the sticky status flags
//   busy, fifo_level      activity and queue occupancy
//   overflow, collision, timeout_err, cmd_err_flag   sticky status flags
module nios2_debug_action_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [37:0]                     jdo,
  input  logic                            take_action_ocimem_a,
  input  logic                            take_action_ocimem_b,
  input  logic                            take_action_break_a,
  input  logic                            take_action_break_b,
  input  logic                            take_action_break_c,
  input  logic                            take_action_tracectrl,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [2:0]                      cmd_type,
  output logic [37:0]                     cmd_payload,
  input  logic                            cmd_done,
  input  logic                            cmd_err,
  input  logic                            clr_status,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            collision,
  output logic                            timeout_err,
  output logic                            cmd_err_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [40:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic       push;
  logic [2:0] push_type;
  logic [2:0] n_strobes;
  logic       multi;
  logic       full;
  logic       empty;
  logic       pop;
  logic       wr_en;
  logic       drop;
  logic       err_set;
  logic       to_set;

  // Fixed-priority capture: ocimem_b beats everything, tracectrl loses to all.
  always_comb begin
    push      = 1'b1;
    push_type = 3'd0;
    if (take_action_ocimem_b)       push_type = 3'd1;
    else if (take_action_ocimem_a)  push_type = 3'd0;
    else if (take_action_break_a)   push_type = 3'd2;
    else if (take_action_break_b)   push_type = 3'd3;
    else if (take_action_break_c)   push_type = 3'd4;
    else if (take_action_tracectrl) push_type = 3'd5;
    else                            push      = 1'b0;
  end

  always_comb begin
    n_strobes = {2'b00, take_action_ocimem_a} + {2'b00, take_action_ocimem_b}
              + {2'b00, take_action_break_a}  + {2'b00, take_action_break_b}
              + {2'b00, take_action_break_c}  + {2'b00, take_action_tracectrl};
    multi   = (n_strobes > 3'd1);
    full    = (fifo_level == LW'(FIFO_DEPTH));
    empty   = (fifo_level == '0);
    pop     = (state == ISSUE) && cmd_valid && cmd_ready;
    // A pop frees the head slot in the same cycle, so a full queue still accepts.
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
    // A done in the expiry cycle is a normal completion, never a timeout.
    err_set = (state == WAIT) && cmd_done && cmd_err;
    to_set  = (state == WAIT) && !cmd_done && (cnt == TO_LAST);
  end

  // Queue storage: contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_type, jdo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      cnt          <= '0;
      cmd_valid    <= 1'b0;
      cmd_type     <= '0;
      cmd_payload  <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      collision    <= 1'b0;
      timeout_err  <= 1'b0;
      cmd_err_flag <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      busy <= (state != IDLE) || (fifo_level != '0);

      case (state)
        IDLE: begin
          if (!empty) begin
            state <= ISSUE;
            cmd_valid <= 1'b1;
            {cmd_type, cmd_payload} <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done || (cnt == TO_LAST)) state <= IDLE;
          else                              cnt   <= cnt + 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase

      // Set events take precedence over a simultaneous clear.
      overflow     <= drop    | (overflow     & ~clr_status);
      collision    <= multi   | (collision    & ~clr_status);
      timeout_err  <= to_set  | (timeout_err  & ~clr_status);
      cmd_err_flag <= err_set | (cmd_err_flag & ~clr_status);
    end
  end

endmodule

// File: tb/tb_nios2_debug_action_sched.sv
module tb_nios2_debug_action_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b;
  logic        take_action_break_a, take_action_break_b, take_action_break_c;
  logic        take_action_tracectrl;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_type;
  logic [37:0] cmd_payload;
  logic        cmd_done, cmd_err, clr_status;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow, collision, timeout_err, cmd_err_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios2_debug_action_sched #(.FIFO_DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_action_break_a(take_action_break_a),
    .take_action_break_b(take_action_break_b),
    .take_action_break_c(take_action_break_c),
    .take_action_tracectrl(take_action_tracectrl),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_payload(cmd_payload), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .clr_status(clr_status), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .collision(collision), .timeout_err(timeout_err),
    .cmd_err_flag(cmd_err_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobes_off();
    take_action_ocimem_a = 0; take_action_ocimem_b = 0;
    take_action_break_a = 0; take_action_break_b = 0;
    take_action_break_c = 0; take_action_tracectrl = 0;
  endtask

  task automatic strobe(input int t);
    strobes_off();
    case (t)
      0: take_action_ocimem_a = 1;
      1: take_action_ocimem_b = 1;
      2: take_action_break_a = 1;
      3: take_action_break_b = 1;
      4: take_action_break_c = 1;
      default: take_action_tracectrl = 1;
    endcase
  endtask

  initial begin
    reset = 1; jdo = '0; strobes_off();
    cmd_ready = 0; cmd_done = 0; cmd_err = 0; clr_status = 0;
    tick(); tick();
    chk("rst_valid", 64'(cmd_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_flags", 64'({overflow, collision, timeout_err, cmd_err_flag}), 0);
    reset = 0;

    // Single ocimem_b strobe, N+2 latency
    cmd_ready = 1;
    jdo = 38'h2A_DEAD_BEEF; strobe(1);
    tick(); strobes_off();                         // N+1
    chk("t1_level_n1", 64'(fifo_level), 1);
    chk("t1_valid_n1", 64'(cmd_valid), 0);
    tick();                                        // N+2
    chk("t1_valid_n2", 64'(cmd_valid), 1);
    chk("t1_type", 64'(cmd_type), 1);
    chk("t1_payload", 64'(cmd_payload), 64'h2A_DEAD_BEEF);
    tick();                                        // N+3, WAIT
    chk("t1_valid_wait", 64'(cmd_valid), 0);
    tick(); tick();                                // N+5
    cmd_done = 1;
    tick(); cmd_done = 0;                          // N+6
    chk("t1_busy_n6", 64'(busy), 1);
    tick();                                        // N+7
    chk("t1_busy_n7", 64'(busy), 0);
    chk("t1_errflag", 64'(cmd_err_flag), 0);

    // Collision: break_a and tracectrl together
    jdo = 38'h1234; take_action_break_a = 1; take_action_tracectrl = 1;
    tick(); strobes_off();
    chk("t2_level", 64'(fifo_level), 1);
    chk("t2_collision", 64'(collision), 1);
    tick();
    chk("t2_valid", 64'(cmd_valid), 1);
    chk("t2_type", 64'(cmd_type), 2);
    chk("t2_level_peak", 64'(fifo_level), 1);
    tick();
    chk("t2_level_after", 64'(fifo_level), 0);
    cmd_done = 1;
    tick(); cmd_done = 0;
    tick();
    chk("t2_single_cmd", 64'(cmd_valid), 0);
    clr_status = 1;
    tick(); clr_status = 0;
    chk("t2_collision_clr", 64'(collision), 0);

    // Overflow: 6 strobes with cmd_ready low
    cmd_ready = 0;
    for (int i = 0; i < 6; i++) begin
      jdo = 38'(100 + i); strobe(i);
      tick();
    end
    strobes_off();
    chk("t3_level_full", 64'(fifo_level), 4);
    chk("t3_overflow", 64'(overflow), 1);
    cmd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_valid%0d", k), 64'(cmd_valid), 1);
      chk($sformatf("t3_type%0d", k), 64'(cmd_type), 64'(k));
      chk($sformatf("t3_payload%0d", k), 64'(cmd_payload), 64'(100 + k));
      tick();
      chk($sformatf("t3_wait%0d", k), 64'(cmd_valid), 0);
      cmd_done = 1;
      tick(); cmd_done = 0;
      tick();
    end
    chk("t3_level_empty", 64'(fifo_level), 0);
    clr_status = 1;
    tick(); clr_status = 0;
    chk("t3_overflow_clr", 64'(overflow), 0);

    // Timeout with TIMEOUT=8, second command queued behind
    jdo = 38'h3; strobe(3);
    tick(); jdo = 38'h4; strobe(4);                // N+1
    tick(); strobes_off();                         // N+2
    chk("t4_type_first", 64'(cmd_type), 3);
    tick();                                        // N+3
    for (int i = 0; i < 7; i++) tick();            // N+10, last WAIT cycle
    chk("t4_no_to_yet", 64'(timeout_err), 0);
    tick();                                        // N+11
    chk("t4_timeout", 64'(timeout_err), 1);
    tick();                                        // N+12
    chk("t4_next_valid", 64'(cmd_valid), 1);
    chk("t4_next_type", 64'(cmd_type), 4);
    tick();                                        // N+13, WAIT
    clr_status = 1;
    tick(); clr_status = 0;                        // N+14
    chk("t4_timeout_clr", 64'(timeout_err), 0);

    // Done with error in the exact expiry cycle
    for (int i = 0; i < 6; i++) tick();            // N+20, cnt = 7
    cmd_done = 1; cmd_err = 1;
    tick(); cmd_done = 0; cmd_err = 0;
    chk("t5_errflag", 64'(cmd_err_flag), 1);
    chk("t5_no_timeout", 64'(timeout_err), 0);
    tick();
    chk("t5_busy", 64'(busy), 0);

    // Set beats clear in the same cycle
    clr_status = 1; take_action_ocimem_a = 1; take_action_ocimem_b = 1;
    tick(); clr_status = 0; strobe(0);             // C+1
    chk("t6_set_wins", 64'(collision), 1);
    chk("t6_errflag_clr", 64'(cmd_err_flag), 0);
    tick(); strobe(2);                             // C+2
    chk("t6_type", 64'(cmd_type), 1);
    tick(); strobes_off();                         // C+3, WAIT
    chk("t6_level_q2", 64'(fifo_level), 2);
    reset = 1;
    tick(); reset = 0;                             // C+4
    chk("t6_rst_valid", 64'(cmd_valid), 0);
    chk("t6_rst_level", 64'(fifo_level), 0);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_flags", 64'({overflow, collision, timeout_err, cmd_err_flag}), 0);
    chk("t6_rst_cmd", 64'({cmd_type, cmd_payload}), 0);
    cmd_done = 1; cmd_err = 1;
    tick(); cmd_done = 0; cmd_err = 0;
    chk("t6_stray_flag", 64'(cmd_err_flag), 0);
    chk("t6_stray_busy", 64'(busy), 0);
    tick();
    chk("t6_stray_valid", 64'(cmd_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios2_debug_action_sched.md
Name: nios2_debug_action_sched

Overview:
- Sequencer between the debug-slave sysclk-side action strobes and the shared OCI register/memory command port.
- Captures each take_action_* strobe, together with the jdo[37:0] payload, into a small FIFO. Issues the queued commands one at a time over a valid/ready request and waits for a done/error response with a timeout.
- Keeps sticky overflow, collision and timeout status for the debug monitor.

Parameters:
- FIFO_DEPTH, 4: command queue depth; power of 2, minimum 2.
- TIMEOUT, 255: maximum WAIT cycles before a command is abandoned; 1..65535.
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- jdo  in  38  JTAG data payload, sampled with any strobe.
- take_action_ocimem_a  in  1  1-cycle strobe, type 0.
- take_action_ocimem_b  in  1  1-cycle strobe, type 1.
- take_action_break_a  in  1  1-cycle strobe, type 2.
- take_action_break_b  in  1  1-cycle strobe, type 3.
- take_action_break_c  in  1  1-cycle strobe, type 4.
- take_action_tracectrl  in  1  1-cycle strobe, type 5.
- cmd_valid  out  1  command presented to the OCI port.
- cmd_ready  in  1  OCI port accepts the command.
- cmd_type  out  3  type code of the presented command.
- cmd_payload  out  38  jdo captured with the command.
- cmd_done  in  1  1-cycle completion pulse from the OCI port.
- cmd_err  in  1  qualifies cmd_done as a failed completion.
- clr_status  in  1  clears the sticky status flags.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a strobe was dropped because the FIFO was full.
- collision  out  1  sticky: more than one strobe arrived in the same cycle.
- timeout_err  out  1  sticky: a command was abandoned on timeout.
- cmd_err_flag  out  1  sticky: a command completed with cmd_err.

Behaviour:
- Reset: all outputs 0, fifo_level 0, FSM in IDLE, timeout counter 0, FIFO pointers 0.
- Capture, at most one push per cycle:
  - If several strobes are high, the highest priority wins: ocimem_b > ocimem_a > break_a > break_b > break_c > tracectrl.
  - The losing strobes are discarded and collision is set.
  - The pushed entry is {type, jdo} as sampled in the strobe cycle.
- FIFO:
  - Push when full with no pop in the same cycle: the entry is dropped, overflow is set, contents are unchanged.
  - Push and pop in the same cycle are both performed, including when full; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM, 3 states:
  - IDLE: go to ISSUE when the FIFO is non-empty.
  - ISSUE: cmd_valid=1. cmd_type and cmd_payload come from the FIFO head and are held stable while cmd_valid is high. When cmd_valid && cmd_ready: pop, clear the counter, go to WAIT.
  - WAIT: cmd_valid=0 and the counter increments each cycle.
    - cmd_done: go to IDLE; if cmd_err, set cmd_err_flag.
    - Counter reaches TIMEOUT-1 without cmd_done: set timeout_err, go to IDLE.
    - cmd_done in the expiry cycle counts as normal completion; no timeout is flagged.
    - cmd_done outside WAIT is ignored.
- Latency:
  - A strobe in cycle N with an empty FIFO and the FSM in IDLE gives cmd_valid in cycle N+2.
  - After a done in cycle M, the next queued command is valid in cycle M+2.
  - Back-to-back commands never overlap, so at most one is outstanding.
- Status:
  - clr_status clears all four sticky flags next cycle.
  - A set event in the same cycle as clr_status wins, so the flag stays 1.
- busy = (state != IDLE) || (fifo_level != 0), registered.
- Reset asserted mid-operation:
  - The FIFO is flushed and cmd_valid drops the next cycle.
  - An in-flight command is forgotten, and a later cmd_done is ignored.

Test Plan:
- Single ocimem_b strobe with jdo=38'h2A_DEAD_BEEF and cmd_ready=1 → cmd_valid at N+2 with cmd_type=1 and cmd_payload=38'h2A_DEAD_BEEF. cmd_done 3 cycles later → busy=0 two cycles after that.
- break_a and tracectrl strobes in the same cycle → exactly one command is issued (type 2), collision=1, fifo_level peaks at 1.
- 6 strobes on consecutive cycles with cmd_ready=0 and FIFO_DEPTH=4 → fifo_level=4, overflow=1, the first 4 types are issued in order once cmd_ready=1.
- Command accepted and cmd_done never asserted, TIMEOUT=8 → timeout_err=1 after 8 WAIT cycles, the next queued command issues; clr_status → timeout_err=0.
- cmd_done with cmd_err=1 in the exact expiry cycle → cmd_err_flag=1, timeout_err=0.
- reset pulsed while in WAIT with 2 entries queued → next cycle all outputs 0, fifo_level=0; a stray cmd_done has no effect.
